// File: rtl/rf_pkg.sv
// Shared types for the register-file access scheduler: channel ids
// for the rotating priority pointer and the per-cycle issue vector.
package rf_pkg;

  localparam int RF_DEPTH      = 32;
  localparam int RF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    CH_W  = 2'd0,
    CH_R1 = 2'd1,
    CH_R2 = 2'd2
  } ch_e;

  typedef struct packed {
    logic wen;
    logic ren1;
    logic ren2;
  } issue_t;

  function automatic ch_e next_ch(input ch_e c);
    ch_e n;
    unique case (c)
      CH_W:    n = CH_R1;
      CH_R1:   n = CH_R2;
      default: n = CH_W;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rf_req_slot.sv
// One-deep request holding slot; ready stays high on the issue cycle
// so a client can refill the slot back to back.
module rf_req_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_issue,
  output logic         o_ready,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic [W-1:0] r_data;

  assign o_ready = ~reset & (~r_full | i_issue);
  assign o_full  = r_full & ~reset;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_valid && o_ready) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_issue) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_access_sched.sv
// Collision-free scheduler in front of the 1W/2R register file.
// Define RF_ACCESS_SCHED_READ_MERGE_EN to merge same-address reads.
module rf_access_sched
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd1_valid,
  output logic                  rd1_ready,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  input  logic                  rd2_valid,
  output logic                  rd2_ready,
  input  logic [ADDR_WIDTH-1:0] rd2_addr,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp2_valid,
  output logic [DATA_WIDTH-1:0] rsp2_data,
  output logic                  wen1,
  output logic [ADDR_WIDTH-1:0] wad1,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  ren1,
  output logic [ADDR_WIDTH-1:0] rad1,
  output logic                  ren2,
  output logic [ADDR_WIDTH-1:0] rad2,
  input  logic [DATA_WIDTH-1:0] dout1,
  input  logic [DATA_WIDTH-1:0] dout2,
  input  logic                  collision,
  output logic                  sched_err
);

  localparam int WW = ADDR_WIDTH + DATA_WIDTH;

  logic                  w_fw;
  logic                  w_f1;
  logic                  w_f2;
  logic [WW-1:0]         w_wslot;
  logic [ADDR_WIDTH-1:0] w_aw;
  logic [ADDR_WIDTH-1:0] w_a1;
  logic [ADDR_WIDTH-1:0] w_a2;
  logic [DATA_WIDTH-1:0] w_dw;
  logic                  w_c1;
  logic                  w_c2;
  logic                  w_c12;
  logic                  w_merge;
  logic                  w_excl;
  issue_t                w_sel;

  ch_e  r_ptr;
  logic r_rsp1;
  logic r_rsp2;
  logic r_merge;
  logic r_err;

  rf_req_slot #(.W(WW)) u_wr (
    .clk     (clk),
    .reset   (reset),
    .i_valid (wr_valid),
    .i_data  ({wr_addr, wr_data}),
    .i_issue (w_sel.wen),
    .o_ready (wr_ready),
    .o_full  (w_fw),
    .o_data  (w_wslot)
  );

  rf_req_slot #(.W(ADDR_WIDTH)) u_rd1 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (rd1_valid),
    .i_data  (rd1_addr),
    .i_issue (w_sel.ren1),
    .o_ready (rd1_ready),
    .o_full  (w_f1),
    .o_data  (w_a1)
  );

  rf_req_slot #(.W(ADDR_WIDTH)) u_rd2 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (rd2_valid),
    .i_data  (rd2_addr),
    .i_issue (w_sel.ren2),
    .o_ready (rd2_ready),
    .o_full  (w_f2),
    .o_data  (w_a2)
  );

  assign {w_aw, w_dw} = w_wslot;
  assign w_c1 = (w_aw == w_a1);
  assign w_c2 = (w_aw == w_a2);

`ifdef RF_ACCESS_SCHED_READ_MERGE_EN
  assign w_c12   = 1'b0;
  assign w_merge = w_sel.ren1 & w_sel.ren2 & (w_a1 == w_a2);
`else
  assign w_c12   = (w_a1 == w_a2);
  assign w_merge = 1'b0;
`endif

  // Greedy pick in pointer order: include a slot unless it clashes
  // with one already chosen earlier in the rotation.
  always_comb begin
    w_sel = '0;
    unique case (r_ptr)
      CH_W: begin
        w_sel.wen  = w_fw;
        w_sel.ren1 = w_f1 & ~(w_sel.wen & w_c1);
        w_sel.ren2 = w_f2 & ~(w_sel.wen & w_c2)
                   & ~(w_sel.ren1 & w_c12);
      end
      CH_R1: begin
        w_sel.ren1 = w_f1;
        w_sel.ren2 = w_f2 & ~(w_sel.ren1 & w_c12);
        w_sel.wen  = w_fw & ~(w_sel.ren1 & w_c1)
                   & ~(w_sel.ren2 & w_c2);
      end
      default: begin
        w_sel.ren2 = w_f2;
        w_sel.wen  = w_fw & ~(w_sel.ren2 & w_c2);
        w_sel.ren1 = w_f1 & ~(w_sel.ren2 & w_c12)
                   & ~(w_sel.wen & w_c1);
      end
    endcase
  end

  assign w_excl = (w_fw & ~w_sel.wen)
                | (w_f1 & ~w_sel.ren1)
                | (w_f2 & ~w_sel.ren2);

  assign wen1 = w_sel.wen;
  assign wad1 = w_sel.wen ? w_aw : '0;
  assign din  = w_sel.wen ? w_dw : '0;
  assign ren1 = w_sel.ren1;
  assign rad1 = w_sel.ren1 ? w_a1 : '0;
  assign ren2 = w_sel.ren2 & ~w_merge;
  assign rad2 = ren2 ? w_a2 : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= CH_W;
      r_rsp1  <= 1'b0;
      r_rsp2  <= 1'b0;
      r_merge <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_excl) r_ptr <= next_ch(r_ptr);
      r_rsp1  <= w_sel.ren1;
      r_rsp2  <= w_sel.ren2;
      r_merge <= w_merge;
      if (collision) r_err <= 1'b1;
    end
  end

  assign rsp1_valid = r_rsp1 & ~reset;
  assign rsp2_valid = r_rsp2 & ~reset;
  assign rsp1_data  = (rsp1_valid & ~collision) ? dout1 : '0;
  assign rsp2_data  = (rsp2_valid & ~collision)
                    ? (r_merge ? dout1 : dout2) : '0;
  assign sched_err  = r_err & ~reset;

endmodule

// File: tb/tb_rf_access_sched.sv
// Scoreboard bench for rf_access_sched with a behavioural 32x16
// register file model driving dout1/dout2 and collision.
module tb_rf_access_sched;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd1_valid;
  logic        rd1_ready;
  logic [4:0]  rd1_addr;
  logic        rd2_valid;
  logic        rd2_ready;
  logic [4:0]  rd2_addr;
  logic        rsp1_valid;
  logic [15:0] rsp1_data;
  logic        rsp2_valid;
  logic [15:0] rsp2_data;
  logic        wen1;
  logic [4:0]  wad1;
  logic [15:0] din;
  logic        ren1;
  logic [4:0]  rad1;
  logic        ren2;
  logic [4:0]  rad2;
  logic [15:0] dout1;
  logic [15:0] dout2;
  logic        collision;
  logic        sched_err;
  logic        force_col;
  logic        m_col;

  int total = 0;
  int bad   = 0;

  logic [15:0] q1[$];
  logic [15:0] q2[$];

  logic [15:0] mem [32];
  bit          mem_init = 1'b0;

  rf_access_sched dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd1_valid(rd1_valid), .rd1_ready(rd1_ready),
    .rd1_addr(rd1_addr),
    .rd2_valid(rd2_valid), .rd2_ready(rd2_ready),
    .rd2_addr(rd2_addr),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rsp2_valid(rsp2_valid), .rsp2_data(rsp2_data),
    .wen1(wen1), .wad1(wad1), .din(din),
    .ren1(ren1), .rad1(rad1), .ren2(ren2), .rad2(rad2),
    .dout1(dout1), .dout2(dout2),
    .collision(collision), .sched_err(sched_err)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'hA500 | 16'(i);
  endfunction

  function automatic logic [15:0] dval(input int r);
    return 16'h2200 + 16'(r);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (wen1) begin
      mem[wad1] <= din;
    end
    if (ren1) dout1 <= mem[rad1];
    if (ren2) dout2 <= mem[rad2];
  end

  assign m_col = (wen1 && ren1 && wad1 == rad1)
              || (wen1 && ren2 && wad1 == rad2)
              || (ren1 && ren2 && rad1 == rad2);
  assign collision = force_col | m_col;

  always @(negedge clk) begin
    logic [15:0] e;
    if (rsp1_valid === 1'b1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL rsp1_unexpected got=%h want=none", rsp1_data);
      end else begin
        e = q1.pop_front();
        if (rsp1_data !== e) begin
          bad++;
          $display("FAIL rsp1_data got=%h want=%h", rsp1_data, e);
        end
      end
    end
    if (rsp2_valid === 1'b1) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL rsp2_unexpected got=%h want=none", rsp2_data);
      end else begin
        e = q2.pop_front();
        if (rsp2_data !== e) begin
          bad++;
          $display("FAIL rsp2_data got=%h want=%h", rsp2_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid  = 1'b0;
    rd1_valid = 1'b0;
    rd2_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] o;
    reset = 1'b1;
    force_col = 1'b0;
    wr_addr = '0; wr_data = '0; rd1_addr = '0; rd2_addr = '0;
    idle_inputs();
    repeat (3) tick();
    @(negedge clk);
    o = {wr_ready, rd1_ready, rd2_ready, wen1, ren1, ren2,
         rsp1_valid, rsp2_valid, sched_err};
    total++;
    if (o !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({wr_ready, rd1_ready, rd2_ready} !== 3'b111) begin
      bad++;
      $display("FAIL reset_readies got=%b want=111",
               {wr_ready, rd1_ready, rd2_ready});
    end
  endtask

  task automatic test_parallel();
    tick();
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 16'hBEEF;
    rd1_valid = 1'b1; rd1_addr = 5'd5;
    rd2_valid = 1'b1; rd2_addr = 5'd7;
    q1.push_back(init_val(5));
    q2.push_back(init_val(7));
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({wen1, ren1, ren2} !== 3'b111) begin
      bad++;
      $display("FAIL par_issue got=%b want=111", {wen1, ren1, ren2});
    end
    total++;
    if ({wad1, rad1, rad2, din} !== {5'd3, 5'd5, 5'd7, 16'hBEEF}) begin
      bad++;
      $display("FAIL par_addr got=%h/%h/%h/%h want=3/5/7/beef",
               wad1, rad1, rad2, din);
    end
    total++;
    if (collision !== 1'b0) begin
      bad++;
      $display("FAIL par_collision got=%b want=0", collision);
    end
    @(negedge clk);
    total++;
    if ({rsp1_valid, rsp2_valid, sched_err} !== 3'b110) begin
      bad++;
      $display("FAIL par_rsp got=%b want=110",
               {rsp1_valid, rsp2_valid, sched_err});
    end
  endtask

  task automatic test_conflict();
    tick();
    wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 16'hBEEF;
    rd1_valid = 1'b1; rd1_addr = 5'd4;
    q1.push_back(16'hBEEF);
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({wen1, ren1, ren2, wad1} !== {3'b100, 5'd4}) begin
      bad++;
      $display("FAIL wr_first got=%b/%h want=100/04",
               {wen1, ren1, ren2}, wad1);
    end
    @(negedge clk);
    total++;
    if ({wen1, ren1, ren2, rad1} !== {3'b010, 5'd4}) begin
      bad++;
      $display("FAIL rd_second got=%b/%h want=010/04",
               {wen1, ren1, ren2}, rad1);
    end
    @(negedge clk);
    total++;
    if (rsp1_valid !== 1'b1) begin
      bad++;
      $display("FAIL conflict_rsp got=%b want=1", rsp1_valid);
    end
  endtask

  task automatic test_same_read();
    tick();
    rd1_valid = 1'b1; rd1_addr = 5'd9;
    rd2_valid = 1'b1; rd2_addr = 5'd9;
    q1.push_back(init_val(9));
    q2.push_back(init_val(9));
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({wen1, ren1, ren2, rad1} !== {3'b010, 5'd9}) begin
      bad++;
      $display("FAIL same_first got=%b/%h want=010/09",
               {wen1, ren1, ren2}, rad1);
    end
`ifdef RF_ACCESS_SCHED_READ_MERGE_EN
    @(negedge clk);
    total++;
    if ({rsp1_valid, rsp2_valid, ren1, ren2} !== 4'b1100) begin
      bad++;
      $display("FAIL merge_rsp got=%b want=1100",
               {rsp1_valid, rsp2_valid, ren1, ren2});
    end
`else
    @(negedge clk);
    total++;
    if ({ren1, ren2, rad2, rsp1_valid} !== {2'b01, 5'd9, 1'b1}) begin
      bad++;
      $display("FAIL same_second got=%b/%h/%b want=01/09/1",
               {ren1, ren2}, rad2, rsp1_valid);
    end
    @(negedge clk);
    total++;
    if ({rsp1_valid, rsp2_valid} !== 2'b01) begin
      bad++;
      $display("FAIL same_rsp2 got=%b want=01",
               {rsp1_valid, rsp2_valid});
    end
`endif
  endtask

  task automatic test_rotation();
    int  wn;
    int  ph;
    int  r;
    bit  acc_w;
    logic [2:0] e;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd2; wr_data = dval(0);
    rd1_valid = 1'b1; rd1_addr = 5'd2;
    rd2_valid = 1'b1; rd2_addr = 5'd2;
    wn = 1;
    acc_w = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (acc_w) begin
        wr_data = dval(wn);
        wn++;
      end
      if (k == 13) idle_inputs();
      @(negedge clk);
      ph = (k - 1) % 3;
      r  = (k - 1) / 3;
      e  = (ph == 0) ? 3'b100 : (ph == 1) ? 3'b010 : 3'b001;
      total++;
      if ({wen1, ren1, ren2} !== e) begin
        bad++;
        $display("FAIL rot_issue k=%0d got=%b want=%b",
                 k, {wen1, ren1, ren2}, e);
      end
      if (ph == 0) begin
        total++;
        if ({wad1, din} !== {5'd2, dval(r)}) begin
          bad++;
          $display("FAIL rot_wdata k=%0d got=%h/%h want=02/%h",
                   k, wad1, din, dval(r));
        end
      end
      if (ph == 1) q1.push_back(dval(r));
      if (ph == 2) q2.push_back(dval(r));
      if (k <= 12) begin
        total++;
        if ({wr_ready, rd1_ready, rd2_ready} !== e) begin
          bad++;
          $display("FAIL rot_ready k=%0d got=%b want=%b",
                   k, {wr_ready, rd1_ready, rd2_ready}, e);
        end
      end
      acc_w = (k <= 12) && (ph == 0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_collision();
    tick();
    rd1_valid = 1'b1; rd1_addr = 5'd5;
    q1.push_back(16'h0000);
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if (ren1 !== 1'b1) begin
      bad++;
      $display("FAIL col_issue got=%b want=1", ren1);
    end
    @(posedge clk); #1;
    force_col = 1'b1;
    @(negedge clk);
    total++;
    if ({rsp1_valid, rsp1_data} !== {1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL col_rsp got=%b/%h want=1/0000",
               rsp1_valid, rsp1_data);
    end
    @(posedge clk); #1;
    force_col = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (sched_err !== 1'b1) begin
        bad++;
        $display("FAIL col_sticky i=%0d got=%b want=1", i, sched_err);
      end
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (sched_err !== 1'b0) begin
      bad++;
      $display("FAIL col_clear got=%b want=0", sched_err);
    end
  endtask

  task automatic test_reset_midop();
    tick();
    rd1_valid = 1'b1; rd1_addr = 5'd5;
    tick();
    rd1_addr = 5'd6;
    @(negedge clk);
    total++;
    if ({ren1, rd1_ready} !== 2'b11) begin
      bad++;
      $display("FAIL mid_issue got=%b want=11", {ren1, rd1_ready});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    total++;
    if ({rsp1_valid, rd1_ready} !== 2'b00) begin
      bad++;
      $display("FAIL mid_in_reset got=%b want=00",
               {rsp1_valid, rd1_ready});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({rd1_ready, ren1} !== 2'b10) begin
      bad++;
      $display("FAIL mid_after got=%b want=10", {rd1_ready, ren1});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (rsp1_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_no_rsp i=%0d got=%b want=0", i, rsp1_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_conflict();
    test_same_read();
`ifndef RF_ACCESS_SCHED_READ_MERGE_EN
    test_rotation();
`endif
    test_collision();
    test_reset_midop();
    repeat (2) @(negedge clk);
    total++;
    if ((q1.size() + q2.size()) != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d want=0/0", q1.size(), q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
